// File: rtl/pipe_front_ctrl_if.sv
// Front-end pipeline control bus: hazard controls, fetch/decode inputs and the
// registered PC, IF/ID, ID/EX and statistics outputs of pipe_front_ctrl.
// Modports: master = the surrounding pipeline (drives controls and fetch data),
//           slave  = pipe_front_ctrl (drives the registered state outputs).
interface pipe_front_ctrl_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int CTRL_WIDTH  = 10,
  parameter int CNT_WIDTH   = 16
);
  // hazard unit controls
  logic                   PC_WriteEn;
  logic                   IFID_WriteEn;
  logic                   Stall_flush;
  // branch resolution from ID
  logic                   Branch_taken;
  logic [PC_WIDTH-1:0]    Branch_target;
  // fetch and decode data
  logic [INSTR_WIDTH-1:0] IF_instr;
  logic [CTRL_WIDTH-1:0]  ID_ctrl;
  // registered pipeline state
  logic [PC_WIDTH-1:0]    PC;
  logic [INSTR_WIDTH-1:0] IFID_instr;
  logic [PC_WIDTH-1:0]    IFID_pc4;
  logic                   IFID_valid;
  logic [CTRL_WIDTH-1:0]  IDEX_ctrl;
  logic                   IDEX_valid;
  // statistics and encoding check
  logic [CNT_WIDTH-1:0]   stall_count;
  logic [CNT_WIDTH-1:0]   flush_count;
  logic                   protocol_err;

  modport master (
    output PC_WriteEn, IFID_WriteEn, Stall_flush, Branch_taken, Branch_target,
           IF_instr, ID_ctrl,
    input  PC, IFID_instr, IFID_pc4, IFID_valid, IDEX_ctrl, IDEX_valid,
           stall_count, flush_count, protocol_err
  );

  modport slave (
    input  PC_WriteEn, IFID_WriteEn, Stall_flush, Branch_taken, Branch_target,
           IF_instr, ID_ctrl,
    output PC, IFID_instr, IFID_pc4, IFID_valid, IDEX_ctrl, IDEX_valid,
           stall_count, flush_count, protocol_err
  );
endinterface

// File: rtl/pipe_front_ctrl.sv
// Purpose: owns PC, IF/ID and ID/EX control registers; applies hazard stalls,
//          bubbles and branch redirects/flushes; keeps stall/flush statistics.
// Latency/backpressure: IF/ID loads 1 cycle after PC, ID/EX 1 cycle later; a
//          stall freezes PC and IF/ID and injects an ID/EX bubble.
// Ports: clk, reset (sync, active-high), bus (pipe_front_ctrl_if.slave).
module pipe_front_ctrl #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter int                  CTRL_WIDTH  = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  CNT_WIDTH   = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_front_ctrl_if.slave  bus
);

  localparam logic [2:0] ENC_RUN   = 3'b110;
  localparam logic [2:0] ENC_STALL = 3'b001;

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_WIDTH-1:0]    ifid_pc4_q, ifid_pc4_d;
  logic                   ifid_valid_q, ifid_valid_d;
  logic [CTRL_WIDTH-1:0]  idex_ctrl_q, idex_ctrl_d;
  logic                   idex_valid_q, idex_valid_d;
  logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;
  logic                   perr_q, perr_d;

  logic [2:0]             enc;
  logic                   illegal;
  logic                   eff_stall;
  logic [PC_WIDTH-1:0]    pc_plus4;

  assign enc       = {bus.PC_WriteEn, bus.IFID_WriteEn, bus.Stall_flush};
  assign illegal   = (enc != ENC_RUN) && (enc != ENC_STALL);
  // Anything that is not a clean run is handled as a stall so a corrupted
  // hazard encoding can never let a dependent instruction slip through.
  assign eff_stall = (enc != ENC_RUN);
  assign pc_plus4  = pc_q + PC_WIDTH'(4);

  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    idex_ctrl_d  = idex_ctrl_q;
    idex_valid_d = idex_valid_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    perr_d       = perr_q | illegal;

    if (eff_stall) begin
      // Branch is deliberately ignored here; it re-resolves next cycle.
      idex_ctrl_d  = '0;
      idex_valid_d = 1'b0;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end else if (bus.Branch_taken) begin
      pc_d         = bus.Branch_target;
      ifid_instr_d = '0;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
      idex_ctrl_d  = bus.ID_ctrl;
      idex_valid_d = ifid_valid_q;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end else begin
      pc_d         = pc_plus4;
      ifid_instr_d = bus.IF_instr;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
      idex_ctrl_d  = ifid_valid_q ? bus.ID_ctrl : '0;
      idex_valid_d = ifid_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      idex_ctrl_q  <= '0;
      idex_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      perr_q       <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      idex_ctrl_q  <= idex_ctrl_d;
      idex_valid_q <= idex_valid_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      perr_q       <= perr_d;
    end
  end

  assign bus.PC           = pc_q;
  assign bus.IFID_instr   = ifid_instr_q;
  assign bus.IFID_pc4     = ifid_pc4_q;
  assign bus.IFID_valid   = ifid_valid_q;
  assign bus.IDEX_ctrl    = idex_ctrl_q;
  assign bus.IDEX_valid   = idex_valid_q;
  assign bus.stall_count  = stall_cnt_q;
  assign bus.flush_count  = flush_cnt_q;
  assign bus.protocol_err = perr_q;

endmodule

// File: doc/pipe_front_ctrl.md
Name: pipe_front_ctrl

Overview:
- Consumes the load-use hazard outputs (PC_WriteEn, IFID_WriteEn, Stall_flush) and applies them to pipeline state.
- Owns the PC register, the IF/ID pipeline register, and the ID/EX control register, and inserts bubbles into ID/EX.
- Applies branch-taken redirects and flushes.
- Sits between instruction memory/fetch and the ID/EX register.
- Also checks the hazard-control encoding and keeps stall/flush statistics.

Parameters:
- PC_WIDTH, 32, PC and PC+4 width
- INSTR_WIDTH, 32, instruction width
- CTRL_WIDTH, 10, width of ID-stage control bundle forwarded to EX
- RESET_PC, 0, PC value after reset
- CNT_WIDTH, 16, width of the statistics counters

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- PC_WriteEn  in  1  1 = PC may advance
- IFID_WriteEn  in  1  1 = IF/ID may load
- Stall_flush  in  1  1 = insert bubble into ID/EX
- Branch_taken  in  1  branch resolved taken in ID this cycle
- Branch_target  in  PC_WIDTH  redirect address
- IF_instr  in  INSTR_WIDTH  instruction fetched at PC
- ID_ctrl  in  CTRL_WIDTH  decoded control for instruction in IF/ID
- PC  out  PC_WIDTH  current fetch address
- IFID_instr  out  INSTR_WIDTH  IF/ID instruction
- IFID_pc4  out  PC_WIDTH  IF/ID PC+4
- IFID_valid  out  1  IF/ID holds a real instruction
- IDEX_ctrl  out  CTRL_WIDTH  ID/EX control bundle
- IDEX_valid  out  1  ID/EX holds a real instruction
- stall_count  out  CNT_WIDTH  cycles with effective stall
- flush_count  out  CNT_WIDTH  accepted branch flushes
- protocol_err  out  1  sticky illegal hazard-input encoding

Behaviour:
- All state updates occur on the rising clk edge. reset is synchronous and dominates every other input.
- Reset values:
  - PC = RESET_PC
  - IFID_instr = 0, IFID_pc4 = 0, IFID_valid = 0
  - IDEX_ctrl = 0, IDEX_valid = 0
  - stall_count = 0, flush_count = 0, protocol_err = 0
- Legal input encodings of {PC_WriteEn, IFID_WriteEn, Stall_flush}:
  - 110 = run
  - 001 = stall
  - Any other value = illegal: sets protocol_err (sticky until reset) and is treated as a stall that cycle.
- effective stall = (encoding == 001) or illegal encoding.
- Priority per cycle: reset > effective stall > Branch_taken > run.
- Effective stall:
  - PC holds.
  - IF/ID holds, all fields.
  - IDEX_ctrl <= 0, IDEX_valid <= 0 (bubble).
  - Branch_taken is ignored; the branch stays in ID and re-resolves next cycle.
  - stall_count += 1, saturating at all-ones.
- Branch_taken, no stall:
  - PC <= Branch_target.
  - IF/ID flushed: IFID_instr <= 0, IFID_pc4 <= 0, IFID_valid <= 0.
  - ID/EX loads the branch normally: IDEX_ctrl <= ID_ctrl, IDEX_valid <= IFID_valid.
  - flush_count += 1, saturating.
- Run:
  - PC <= PC + 4, modulo 2^PC_WIDTH (all-ones-minus-3 wraps to 0).
  - IFID_instr <= IF_instr, IFID_pc4 <= PC + 4, IFID_valid <= 1.
  - IDEX_ctrl <= IFID_valid ? ID_ctrl : 0; IDEX_valid <= IFID_valid.
- Latency:
  - Fetched instruction appears in IF/ID 1 cycle after its PC is presented.
  - Its control appears in ID/EX 1 cycle later.
  - A stall of N cycles delays both by N.
- Counter saturation: a counter at all-ones stays at all-ones; no wrap.
- The block contains no combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset, then 3 run cycles (110), IF_instr = 0x8C120004, 0x02519020, 0x00000000 -> PC = 0, 4, 8, 12; IFID_instr = 0x8C120004 at cycle 1 with IFID_pc4 = 4; IDEX_valid = 1 from cycle 2; counters 0.
- Load-use: run, then one stall cycle (001), then run -> PC and IF/ID unchanged across the stall cycle; IDEX_ctrl = 0 and IDEX_valid = 0 the cycle after the stall; stall_count = 1; protocol_err = 0.
- Branch with 110 and Branch_taken = 1, Branch_target = 0x40 -> next PC = 0x40, IFID_valid = 0, IFID_instr = 0, flush_count = 1; following cycle IF/ID loads the 0x40 instruction.
- Simultaneous stall (001) and Branch_taken = 1, target 0x80 -> PC holds, flush_count unchanged, bubble inserted; next cycle Branch_taken = 1 with 110 -> PC = 0x80, flush_count = 1.
- Illegal encodings 100, then 011 -> each treated as a stall (PC holds, bubble); protocol_err = 1 from the first and stays 1; stall_count = 2; after reset protocol_err = 0.
- Wrap and saturation:
  - RESET_PC = 0xFFFFFFFC, one run cycle -> PC = 0x00000000, IFID_pc4 = 0.
  - CNT_WIDTH = 4 with 20 consecutive stalls -> stall_count = 15 and holds.
